// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: computes one result bit per cycle, LSB first, through a
// single-bit datapath, then presents the full result and flags with a one-cycle done pulse.
module alu_serial_sequencer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [IW-1:0]    idx_q;
    logic             c_q;
    // Holds the bits produced so far; bit k ends at position k after WIDTH-1 shifts.
    logic [WIDTH-2:0] sh_q;
    logic             busy_q, done_q, neg_q, zero_q, ovf_q, cout_q;
    logic [WIDTH-1:0] result_q;

    logic             is_arith, b_eff, sum_bit, c_d, bit_res, accept;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        is_arith = (op_q == 3'b010) || (op_q == 3'b011);
        b_eff    = b_q[0] ^ (is_arith & op_q[0]);
        sum_bit  = a_q[0] ^ b_eff ^ c_q;
        c_d      = (a_q[0] & b_eff) | (a_q[0] & c_q) | (b_eff & c_q);
        bit_res  = 1'b0;
        case (op_q)
            3'b000:  bit_res = b_q[0];
            3'b010:  bit_res = sum_bit;
            3'b011:  bit_res = sum_bit;
            3'b100:  bit_res = a_q[0] & b_q[0];
            3'b101:  bit_res = a_q[0] | b_q[0];
            3'b110:  bit_res = a_q[0] ^ b_q[0];
            default: bit_res = 1'b0;
        endcase
        shift_d = {bit_res, sh_q};
        accept  = start && ((state_q == StIdle) || (state_q == StDone));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            sh_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= cntrl;
                idx_q <= '0;
                c_q   <= ((cntrl == 3'b010) || (cntrl == 3'b011)) ? cntrl[0] : 1'b0;
            end
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_d;
                    sh_q  <= shift_d[WIDTH-1:1];
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_q  <= StDone;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= shift_d;
                        neg_q    <= shift_d[WIDTH-1];
                        zero_q   <= (shift_d == '0);
                        // c_q is the carry into the MSB, c_d the carry out of it.
                        ovf_q    <= is_arith & (c_q ^ c_d);
                        cout_q   <= is_arith & c_d;
                    end
                end
                StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: directed vector table, multi-cycle corner
// sequences, and random operations against an arithmetic reference model.
module tb_alu_serial_sequencer;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         busy, done, negative, zero, overflow, carry_out;
    logic [W-1:0] result;

    int checks = 0;
    int failures = 0;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (a),
        .B         (b),
        .cntrl     (op),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         n, z, v, c;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [2:0] o, output logic [W-1:0] r,
                                  output logic n, output logic z, output logic v,
                                  output logic c);
        logic [W:0] s;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (o)
            3'b000: r = y;
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b011: begin
                s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'b100: r = x & y;
            3'b101: r = x | y;
            3'b110: r = x ^ y;
            default: r = '0;
        endcase
        n = r[W-1];
        z = (r == '0);
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        op    = o;
    endtask

    // Waits for done while scrambling operands; lat is negedges after the start cycle.
    task automatic wait_done(output int lat, output logic busy1, output logic [W-1:0] mid_res);
        lat     = -1;
        busy1   = 1'b0;
        mid_res = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                busy1 = busy;
            end
            if (i == 30) mid_res = result;
            if (done) begin
                lat = i;
                break;
            end
            a  = rnd64();
            b  = rnd64();
            op = 3'($urandom);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic n,
                             input logic z, input logic v, input logic c);
        check({tag, ".result"}, result, r);
        check({tag, ".flags_nzvc"}, {negative, zero, overflow, carry_out}, {n, z, v, c});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy_done"}, {busy, done}, 2'b00);
        check_out(tag, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    vec_t         tbl[8];
    int           lat, lat2, ndone, first;
    logic         b1;
    logic [W-1:0] mid, er, er2, x1, y1;
    logic         en, ez, ev, ec, en2, ez2, ev2, ec2;
    logic [2:0]   o1;

    initial begin
        tbl[0] = '{3'b010, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{3'b011, 64'd5, 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{3'b011, 64'd3, 64'd5, 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3'b100, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF000F000F000F000,
                   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{3'b101, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hFFF0FFF0FFF0FFF0,
                   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{3'b110, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'h0FF00FF00FF00FF0,
                   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{3'b000, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hFF00FF00FF00FF00,
                   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{3'b111, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        op    = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Directed vectors
        for (int k = 0; k < 8; k++) begin
            launch(tbl[k].a, tbl[k].b, tbl[k].op);
            wait_done(lat, b1, mid);
            check($sformatf("vec%0d.latency", k), 64'(lat), 64'd65);
            check($sformatf("vec%0d.busy", k), 64'(b1), 64'd1);
            check_out($sformatf("vec%0d", k), tbl[k].r, tbl[k].n, tbl[k].z, tbl[k].v, tbl[k].c);
            @(negedge clk);
            check($sformatf("vec%0d.done_width", k), 64'(done), 64'd0);
        end

        // Start during RUN is ignored
        x1 = 64'h0123456789ABCDEF;
        y1 = 64'h1111111111111111;
        model(x1, y1, 3'b010, er, en, ez, ev, ec);
        launch(x1, y1, 3'b010);
        ndone = 0;
        first = -1;
        for (int i = 1; i <= 140; i++) begin
            @(negedge clk);
            start = (i == 20);
            if (i == 20) begin
                a  = 64'hDEADBEEFDEADBEEF;
                b  = 64'h5;
                op = 3'b110;
            end
            if (done) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        check("busystart.latency", 64'(first), 64'd65);
        check("busystart.done_count", 64'(ndone), 64'd1);
        check_out("busystart", er, en, ez, ev, ec);

        // Reset mid-RUN, with start asserted alongside reset
        launch(64'h7, 64'h9, 3'b010);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_reset_vals("midreset");
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset.no_done", 64'(ndone), 64'd0);
        model(64'h40, 64'h3, 3'b011, er, en, ez, ev, ec);
        launch(64'h40, 64'h3, 3'b011);
        wait_done(lat, b1, mid);
        check("postreset.latency", 64'(lat), 64'd65);
        check_out("postreset", er, en, ez, ev, ec);

        // Back-to-back: start held in the DONE cycle
        x1 = 64'h8000000000000000;
        y1 = 64'h8000000000000000;
        model(x1, y1, 3'b010, er, en, ez, ev, ec);
        model(64'hAAAA, 64'h5555, 3'b111, er2, en2, ez2, ev2, ec2);
        launch(x1, y1, 3'b010);
        wait_done(lat, b1, mid);
        check("b2b.first_latency", 64'(lat), 64'd65);
        check_out("b2b.first", er, en, ez, ev, ec);
        start = 1'b1;
        a     = 64'hAAAA;
        b     = 64'h5555;
        op    = 3'b111;
        wait_done(lat2, b1, mid);
        check("b2b.busy_next", 64'(b1), 64'd1);
        check("b2b.held_result", mid, er);
        check("b2b.second_latency", 64'(lat2), 64'd65);
        check_out("b2b.second", er2, en2, ez2, ev2, ec2);

        // Random operations against the model
        for (int k = 0; k < 40; k++) begin
            x1 = rnd64();
            y1 = ($urandom_range(0, 3) == 0) ? x1 : rnd64();
            o1 = 3'($urandom_range(0, 7));
            model(x1, y1, o1, er, en, ez, ev, ec);
            launch(x1, y1, o1);
            wait_done(lat, b1, mid);
            check($sformatf("rnd%0d.latency", k), 64'(lat), 64'd65);
            check_out($sformatf("rnd%0d_op%0d", k, o1), er, en, ez, ev, ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
